wash_cycle_controller: RTL
==========================

Name: wash_cycle_controller

Overview:
Top-level washing-machine sequencer that sits directly upstream of the multi-phase timer. It drives the timer's phase select, enable and start inputs and consumes its done flag. It also sequences water valve, drain pump, motor and door lock through a fixed soak/wash/rinse/spin programme. Water-level, door and pause inputs from the front panel and sensors gate progress; a fill watchdog flags plumbing faults.

Parameters:
FILL_TIMEOUT, 500, max cycles in a FILL state before entering ERROR
DRAIN_CYCLES, 64, fixed cycles spent in DRAIN (counter-based, no timer use)
GUARD_CYCLES, 2, cycles after a timer_start pulse during which timer_done is ignored

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_btn  in  1  level; rising edge (internally detected) starts a cycle from IDLE or clears ERROR
door_closed  in  1  door sensor, 1 = closed
water_full  in  1  level sensor, 1 = drum full
pause  in  1  level; 1 holds current phase
timer_done  in  1  phase-time-expired flag from timer
phase_sel  out  2  00 soak, 01 wash, 10 rinse, 11 spin
timer_enable  out  1  timer count enable
timer_start  out  1  one-cycle pulse on entry to each timed phase
water_valve  out  1  inlet valve open
drain_pump  out  1  drain pump on
motor_on  out  1  drum motor on (agitate)
motor_spin  out  1  high-speed spin
door_lock  out  1  door latch engaged
cycle_done  out  1  programme complete indicator
fault  out  1  fill-timeout error indicator
state_out  out  4  current state encoding, for panel/debug

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; phase_sel 00; counters and guard cleared; start edge detector register 0.
- States: IDLE, FILL1, SOAK, WASH, DRAIN1, FILL2, RINSE, DRAIN2, SPIN, DONE, ERROR. Registered (Moore) outputs.
- IDLE: start_btn rising edge AND door_closed -> FILL1. Edge with door open is ignored (not remembered).
- FILL1/FILL2: water_valve=1; water_full -> SOAK (FILL1) / RINSE (FILL2). Fill counter increments each non-paused cycle; reaching FILL_TIMEOUT -> ERROR. Counter cleared on entry.
- SOAK/WASH/RINSE/SPIN: phase_sel = 00/01/10/11; timer_start=1 for exactly the first cycle in state; timer_enable=1 whenever in state and not held; motor_on=1 in WASH and RINSE; motor_spin=1 and drain_pump=1 in SPIN.
- Timed-phase exit: timer_done=1 after guard expires -> SOAK->WASH, WASH->DRAIN1, RINSE->DRAIN2, SPIN->DONE. Guard: timer_done ignored for GUARD_CYCLES cycles beginning with the timer_start cycle.
- DRAIN1/DRAIN2: drain_pump=1; internal counter; after DRAIN_CYCLES cycles -> FILL2 / SPIN.
- Hold: pause=1 OR door_closed=0 in any state other than IDLE/DONE/ERROR freezes state, counters and guard; timer_enable, water_valve, motor_on, motor_spin, drain_pump forced 0; timer_start pulse is not re-issued on release. Door open mid-cycle also asserts nothing else; resumes where held once closed and pause=0.
- door_lock=1 in every state except IDLE, DONE, ERROR.
- DONE: cycle_done=1; returns to IDLE when door_closed falls or on new start_btn edge (edge goes to IDLE, not FILL1; second edge starts).
- ERROR: fault=1, all actuators 0, door_lock 0; start_btn edge -> IDLE.
- Simultaneous: hold takes priority over timer_done, water_full and counter expiry in same cycle; fill timeout and water_full in same cycle -> water_full wins.
- Reset mid-cycle: immediate return to IDLE with all actuators off.

Decomposition:
- Shared package: phase encodings (PH_SOAK..PH_SPIN), state enum encoding (4-bit), default parameter constants; timer reuses phase encodings.
- One sub-module natural: wcc_phase_counter (loadable down-counter with hold input) used for fill watchdog and drain timing; FSM stays in top.

Test Plan:
- Full programme: door closed, start edge, water_full 3 cycles after each fill, timer_done pulsed 10 cycles after each timer_start -> states visit FILL1,SOAK,WASH,DRAIN1,FILL2,RINSE,DRAIN2,SPIN,DONE; phase_sel 00,01,10,11 in order; exactly 4 timer_start pulses; cycle_done=1.
- Stale done: timer_done held 1 across WASH entry -> no advance during first 2 cycles of WASH; advance on cycle 3.
- Pause in WASH for 20 cycles -> state unchanged, timer_enable=0, motor_on=0; on release motor_on=1, no new timer_start.
- Fill timeout: water_full never asserted -> ERROR after 500 cycles, fault=1, valve 0, door_lock 0; start edge -> IDLE.
- Start with door open -> stays IDLE, door_lock 0; door closes later without new edge -> still IDLE.
- rst_n asserted mid-SPIN -> all outputs 0 asynchronously, state_out=IDLE.

Source files
------------

// File: rtl/wash_cycle_controller_pkg.sv
// Shared definitions for the washing-machine sequencer and its timer interface.
// Contents: phase encodings (also used by the multi-phase timer), 4-bit state
// encoding, default programme constants and small state-classification helpers.
package wash_cycle_controller_pkg;

  localparam int unsigned FILL_TIMEOUT_DEF = 500;
  localparam int unsigned DRAIN_CYCLES_DEF = 64;
  localparam int unsigned GUARD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    PH_SOAK  = 2'b00,
    PH_WASH  = 2'b01,
    PH_RINSE = 2'b10,
    PH_SPIN  = 2'b11
  } phase_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FILL1  = 4'd1,
    ST_SOAK   = 4'd2,
    ST_WASH   = 4'd3,
    ST_DRAIN1 = 4'd4,
    ST_FILL2  = 4'd5,
    ST_RINSE  = 4'd6,
    ST_DRAIN2 = 4'd7,
    ST_SPIN   = 4'd8,
    ST_DONE   = 4'd9,
    ST_ERROR  = 4'd10
  } state_e;

  // Phases that run against the external timer.
  function automatic logic is_timed(input state_e s);
    return s inside {ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN};
  endfunction

  // States in which the door is locked and hold (pause / door open) applies.
  function automatic logic is_active(input state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

  function automatic logic is_fill(input state_e s);
    return s inside {ST_FILL1, ST_FILL2};
  endfunction

  function automatic logic is_drain(input state_e s);
    return s inside {ST_DRAIN1, ST_DRAIN2};
  endfunction

  function automatic phase_e phase_of(input state_e s);
    case (s)
      ST_WASH:  return PH_WASH;
      ST_RINSE: return PH_RINSE;
      ST_SPIN:  return PH_SPIN;
      default:  return PH_SOAK;
    endcase
  endfunction

endpackage

// File: rtl/wcc_phase_counter.sv
// Loadable down-counter with hold, shared by the fill watchdog and drain timer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       load load_val_i this cycle (overrides hold)
//   load_val_i   number of counted cycles until last_o
//   hold_i       freeze the count
//   last_o       registered; high while the count equals 1 (final counted cycle)
module wcc_phase_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         hold_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement toward zero unless held.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!hold_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_o <= (cnt_d == W'(1));
    end
  end

endmodule

// File: rtl/wash_cycle_controller.sv
// Washing-machine programme sequencer: FILL1, SOAK, WASH, DRAIN1, FILL2, RINSE,
// DRAIN2, SPIN, DONE with an ERROR state for fill timeout. Drives the
// multi-phase timer and all actuators; every output is registered.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_btn                  start level (rising edge detected internally)
//   door_closed, water_full    sensors
//   pause                      panel pause level
//   timer_done                 timer phase-expired flag
//   phase_sel, timer_enable,
//   timer_start                timer control (start is a one-cycle entry pulse)
//   water_valve, drain_pump,
//   motor_on, motor_spin,
//   door_lock                  actuators
//   cycle_done, fault          status
//   state_out                  current state encoding
module wash_cycle_controller
  import wash_cycle_controller_pkg::*;
#(
  parameter int unsigned FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       pause,
  input  logic       timer_done,
  output logic [1:0] phase_sel,
  output logic       timer_enable,
  output logic       timer_start,
  output logic       water_valve,
  output logic       drain_pump,
  output logic       motor_on,
  output logic       motor_spin,
  output logic       door_lock,
  output logic       cycle_done,
  output logic       fault,
  output logic [3:0] state_out
);

  localparam int unsigned CNT_MAX = (FILL_TIMEOUT > DRAIN_CYCLES) ? FILL_TIMEOUT : DRAIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned GRD_W   = $clog2(GUARD_CYCLES + 2);

  state_e           state_q, state_d;
  logic             start_q;
  logic [GRD_W-1:0] guard_q, guard_d;

  logic             start_edge_c;
  logic             hold_c;
  logic             out_hold_c;
  logic             state_entry_c;
  logic             phase_go_c;
  logic             cnt_load_c;
  logic             cnt_hold_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             cnt_last;

  logic [1:0] phase_sel_d;
  logic       timer_enable_d, timer_start_d, water_valve_d, drain_pump_d;
  logic       motor_on_d, motor_spin_d, door_lock_d, cycle_done_d, fault_d;

  assign start_edge_c = start_btn & ~start_q;
  // Hold freezes the programme only while a cycle is actually running.
  assign hold_c       = (pause | ~door_closed) & is_active(state_q);
  // A stale timer_done is ignored until the guard window after entry has run out.
  assign phase_go_c   = ~hold_c & (guard_q == '0) & timer_done;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_edge_c && door_closed) state_d = ST_FILL1;
      ST_FILL1: begin
        if (!hold_c) begin
          if (water_full)    state_d = ST_SOAK;
          else if (cnt_last) state_d = ST_ERROR;
        end
      end
      ST_SOAK:   if (phase_go_c) state_d = ST_WASH;
      ST_WASH:   if (phase_go_c) state_d = ST_DRAIN1;
      ST_DRAIN1: if (!hold_c && cnt_last) state_d = ST_FILL2;
      ST_FILL2: begin
        if (!hold_c) begin
          if (water_full)    state_d = ST_RINSE;
          else if (cnt_last) state_d = ST_ERROR;
        end
      end
      ST_RINSE:  if (phase_go_c) state_d = ST_DRAIN2;
      ST_DRAIN2: if (!hold_c && cnt_last) state_d = ST_SPIN;
      ST_SPIN:   if (phase_go_c) state_d = ST_DONE;
      ST_DONE:   if (!door_closed || start_edge_c) state_d = ST_IDLE;
      ST_ERROR:  if (start_edge_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign state_entry_c = (state_d != state_q);

  // Guard window: reloaded on timed-phase entry, counts down only while running.
  always_comb begin
    guard_d = guard_q;
    if (state_entry_c && is_timed(state_d)) begin
      guard_d = GRD_W'(GUARD_CYCLES);
    end else if (is_timed(state_q) && !hold_c && (guard_q != '0)) begin
      guard_d = guard_q - GRD_W'(1);
    end
  end

  // Shared counter: fill watchdog in FILL states, fixed duration in DRAIN states.
  assign cnt_load_c = state_entry_c & (is_fill(state_d) | is_drain(state_d));
  assign cnt_val_c  = is_fill(state_d) ? CNT_W'(FILL_TIMEOUT) : CNT_W'(DRAIN_CYCLES);
  assign cnt_hold_c = hold_c | ~(is_fill(state_q) | is_drain(state_q));

  wcc_phase_counter #(
    .W (CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .hold_i     (cnt_hold_c),
    .last_o     (cnt_last)
  );

  // Moore outputs for the state being entered, gated by the current hold inputs.
  always_comb begin
    out_hold_c     = (pause | ~door_closed) & is_active(state_d);
    phase_sel_d    = 2'(PH_SOAK);
    if (is_timed(state_d)) phase_sel_d = 2'(phase_of(state_d));
    timer_start_d  = is_timed(state_d) & state_entry_c;
    timer_enable_d = is_timed(state_d) & ~out_hold_c;
    water_valve_d  = is_fill(state_d) & ~out_hold_c;
    drain_pump_d   = (is_drain(state_d) | (state_d == ST_SPIN)) & ~out_hold_c;
    motor_on_d     = ((state_d == ST_WASH) | (state_d == ST_RINSE)) & ~out_hold_c;
    motor_spin_d   = (state_d == ST_SPIN) & ~out_hold_c;
    door_lock_d    = is_active(state_d);
    cycle_done_d   = (state_d == ST_DONE);
    fault_d        = (state_d == ST_ERROR);
  end

  // State, edge detector, guard and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      guard_q      <= '0;
      phase_sel    <= 2'b00;
      timer_enable <= 1'b0;
      timer_start  <= 1'b0;
      water_valve  <= 1'b0;
      drain_pump   <= 1'b0;
      motor_on     <= 1'b0;
      motor_spin   <= 1'b0;
      door_lock    <= 1'b0;
      cycle_done   <= 1'b0;
      fault        <= 1'b0;
      state_out    <= 4'(ST_IDLE);
    end else begin
      state_q      <= state_d;
      start_q      <= start_btn;
      guard_q      <= guard_d;
      phase_sel    <= phase_sel_d;
      timer_enable <= timer_enable_d;
      timer_start  <= timer_start_d;
      water_valve  <= water_valve_d;
      drain_pump   <= drain_pump_d;
      motor_on     <= motor_on_d;
      motor_spin   <= motor_spin_d;
      door_lock    <= door_lock_d;
      cycle_done   <= cycle_done_d;
      fault        <= fault_d;
      state_out    <= 4'(state_d);
    end
  end

endmodule
